axis_pkt_ring_axi4_writer: RTL and testbench
============================================

AXIS_PKT_RING_AXI4_WRITER -- requirements
Module: axis_pkt_ring_axi4_writer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, AXI address width; DATA_WIDTH, default 512, stream/AXI data width (BEAT_BYTES=DATA_WIDTH/8); ID_WIDTH, default 4, AXI ID width; AXI_ID, default 0, constant awid value; MAX_BURST, default 16, max beats per burst (power of 2, 1..256); MAX_OUTSTANDING, default 4, max unacknowledged bursts.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  packet input stream.
REQ-005 s_axis_tkeep  in  BEAT_BYTES  byte enables (present only with REQ-026 macro).
REQ-006 m_axi_aw{id,addr,len,size,burst,valid,ready}  out(ready in)  ID_WIDTH/ADDR_WIDTH/8/3/2/1/1  AXI4 write address.
REQ-007 m_axi_w{data,strb,last,valid,ready}  out(ready in)  DATA_WIDTH/BEAT_BYTES/1/1/1  AXI4 write data.
REQ-008 m_axi_b{id,resp,valid,ready}  in/in/in/out  ID_WIDTH/2/1/1  AXI4 write response.
REQ-009 enable  in  1  accept new packets; ring_base  in  ADDR_WIDTH  ring start, 4 KiB aligned; ring_size  in  ADDR_WIDTH  ring bytes, nonzero multiple of 4 KiB.
REQ-010 wr_ptr  out  ADDR_WIDTH  next write offset in ring; pkt_count  out  32  packets completed; outstanding  out  8  bursts awaiting B; bresp_err  out  1  sticky non-OKAY response flag.

Function
REQ-011 Block SHALL store up to MAX_BURST beats (data, strobe) in an internal burst buffer, then issue one AW followed by its W beats (store-and-forward per burst).
REQ-012 FSM states SHALL be FILL, ADDR, DATA; reset state FILL.
REQ-013 FILL: s_axis_tready=1 iff cnt<limit and (mid-packet or enable=1); limit=min(MAX_BURST, beats from base+wr_ptr to next 4 KiB boundary).
REQ-014 FILL->ADDR when accepted beat makes cnt==limit or carries tlast; ADDR asserts awvalid only when outstanding<MAX_OUTSTANDING.
REQ-015 AW fields: awaddr=ring_base+wr_ptr, awlen=cnt-1, awsize=log2(BEAT_BYTES), awburst=2'b01, awid=AXI_ID; stable while awvalid=1 and awready=0.
REQ-016 ADDR->DATA on awvalid&awready; DATA drives buffered beats in order, wlast on beat cnt-1, wvalid held until wready; DATA->FILL on final handshake, cnt cleared.
REQ-017 On AW handshake wr_ptr SHALL advance by cnt*BEAT_BYTES, wrapping to 0 when result equals ring_size; bursts never cross 4 KiB or ring end.
REQ-018 outstanding SHALL increment on AW handshake, decrement on B handshake, unchanged on both same cycle; m_axi_bready=1 always.
REQ-019 bresp!=2'b00 on B handshake SHALL set bresp_err until reset.
REQ-020 pkt_count SHALL increment (wrapping) on AW handshake of the burst containing tlast.
REQ-021 Every packet SHALL start at a beat boundary; partial last beat leaves remainder of that beat unused.
REQ-022 enable is sampled only at packet start; deassertion mid-packet takes effect after tlast; ring_base/ring_size latched at packet start.
REQ-023 Zero-bubble: W beats SHALL issue back-to-back while wready=1.

Reset
REQ-024 On rst: state FILL, cnt=0, wr_ptr=0, pkt_count=0, outstanding=0, bresp_err=0, awvalid=0, wvalid=0, wlast=0, s_axis_tready=0 in reset cycle.
REQ-025 Reset mid-burst SHALL abandon buffered beats and in-flight bursts with no further AW/W issued; late B responses after reset are ignored.

Configuration
REQ-026 Macro AXIS_RING_WRITER_TKEEP_EN: defined -> s_axis_tkeep port exists and wstrb=buffered tkeep per beat; undefined -> no tkeep port, wstrb all ones.

Verification (DATA_WIDTH=512, MAX_BURST=16, ring_base=0x1000_0000, ring_size=0x10000)
REQ-027 400 B packet (7 beats) -> one AW addr 0x1000_0000 awlen 6, 7 W beats, wlast on 7th, wr_ptr=0x1C0, pkt_count=1.
REQ-028 2048 B packet (32 beats) -> AWs awlen 15 at 0x1000_0000 and 0x1000_0400, wr_ptr=0x800.
REQ-029 wr_ptr=0xE00, 1024 B packet -> AW awlen 7 at 0x1000_0E00, AW awlen 7 at 0x1000_1000.
REQ-030 ring_size=0x1000, wr_ptr=0xF80, 256 B packet -> AW awlen 1 at 0x1000_0F80, AW awlen 1 at 0x1000_0000, wr_ptr=0x080.
REQ-031 bvalid held 0, five 1-beat packets -> 4 AWs, fifth awvalid low until one B (bresp=2'b10) returns, then issued; bresp_err=1.
REQ-032 rst pulsed during DATA beat 3 of 8 -> wvalid=0 next cycle, all counters 0, next packet starts at ring_base.

Source files
------------

// File: rtl/axis_pkt_ring_axi4_writer.sv
// axis_pkt_ring_axi4_writer
//   Writes an AXI-Stream packet flow into a circular buffer in memory through
//   an AXI4 write master. Beats are collected into a local burst buffer (up to
//   MAX_BURST beats, never crossing a 4 KiB page or the ring end), then one AW
//   is issued followed by the buffered W beats back-to-back.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : packet input stream (tkeep only with the macro below)
//   m_axi_aw*/w*/b*   : AXI4 write address / data / response channels
//   enable            : allow a new packet to start
//   ring_base/size    : ring location (4 KiB aligned) and size (4 KiB multiple)
//   wr_ptr            : next write offset inside the ring
//   pkt_count         : packets whose last burst has been addressed
//   outstanding       : bursts addressed but not yet acknowledged
//   bresp_err         : sticky flag, a non-OKAY write response was seen
//
// Build option
//   AXIS_RING_WRITER_TKEEP_EN : adds s_axis_tkeep and forwards it as wstrb;
//                               without it wstrb is all ones.
module axis_pkt_ring_axi4_writer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 4,
  parameter int AXI_ID          = 0,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
`ifdef AXIS_RING_WRITER_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
`endif
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   ring_base,
  input  logic [ADDR_WIDTH-1:0]   ring_size,
  output logic [ADDR_WIDTH-1:0]   wr_ptr,
  output logic [31:0]             pkt_count,
  output logic [7:0]              outstanding,
  output logic                    bresp_err
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int SZ         = $clog2(BEAT_BYTES);
  localparam int CW         = $clog2(MAX_BURST + 1);
  localparam int IW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {FILL, ADDR, DATA} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0]         r_cnt, r_rd;
  logic                  r_mid, r_has_last, r_bresp_err;
  logic [ADDR_WIDTH-1:0] r_base, r_size, r_wr_ptr;
  logic [31:0]           r_pkt_count;
  logic [7:0]            r_outstanding;
  logic [DATA_WIDTH-1:0] r_data_buf [MAX_BURST];
  logic [BEAT_BYTES-1:0] r_strb_buf [MAX_BURST];

  logic                  w_tready, w_awvalid, w_wvalid;
  logic                  w_accept, w_aw_hs, w_w_hs, w_b_hs, w_last_beat;
  logic [BEAT_BYTES-1:0] w_strb_in;
  logic [ADDR_WIDTH-1:0] w_base, w_addr, w_ptr_adv;
  logic [12:0]           w_room, w_room_beats;
  logic [CW-1:0]         w_limit;
  logic                  w_unused;

`ifdef AXIS_RING_WRITER_TKEEP_EN
  assign w_strb_in = s_axis_tkeep;
`else
  assign w_strb_in = '1;
`endif

  // At a packet start the live ring_base applies; mid-packet the latched one.
  assign w_base       = r_mid ? r_base : ring_base;
  assign w_addr       = w_base + r_wr_ptr;
  // Ring end is always a 4 KiB boundary, so the page limit also stops bursts
  // at the wrap point.
  assign w_room       = 13'h1000 - {1'b0, w_addr[11:0]};
  assign w_room_beats = w_room >> SZ;
  assign w_limit      = (w_room_beats >= 13'(MAX_BURST)) ? CW'(MAX_BURST)
                                                         : w_room_beats[CW-1:0];
  assign w_last_beat  = (r_rd == r_cnt - CW'(1));
  assign w_ptr_adv    = r_wr_ptr + (ADDR_WIDTH'(r_cnt) << SZ);

  assign w_accept = s_axis_tvalid && w_tready;
  assign w_aw_hs  = w_awvalid && m_axi_awready;
  assign w_w_hs   = w_wvalid && m_axi_wready;
  // A response with nothing outstanding belongs to a burst abandoned by reset.
  assign w_b_hs   = m_axi_bvalid && (r_outstanding != 8'd0);
  assign w_unused = ^{m_axi_bid, w_addr[ADDR_WIDTH-1:12]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    case (r_state)
      FILL: begin
        w_tready = !rst && (r_cnt < w_limit) && (r_mid || enable);
        if (s_axis_tvalid && w_tready &&
            ((r_cnt + CW'(1) == w_limit) || s_axis_tlast))
          w_state_nxt = ADDR;
      end
      ADDR: begin
        w_awvalid = !rst && (r_outstanding < 8'(MAX_OUTSTANDING));
        if (w_awvalid && m_axi_awready) w_state_nxt = DATA;
      end
      DATA: begin
        w_wvalid = !rst;
        if (m_axi_wready && w_last_beat) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_rd          <= '0;
      r_mid         <= 1'b0;
      r_has_last    <= 1'b0;
      r_base        <= '0;
      r_size        <= '0;
      r_wr_ptr      <= '0;
      r_pkt_count   <= '0;
      r_outstanding <= '0;
      r_bresp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= r_cnt + CW'(1);
        r_mid      <= !s_axis_tlast;
        r_has_last <= s_axis_tlast;
        if (!r_mid) begin
          r_base <= ring_base;
          r_size <= ring_size;
        end
      end
      if (w_aw_hs) begin
        r_wr_ptr <= (w_ptr_adv == r_size) ? '0 : w_ptr_adv;
        if (r_has_last) r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_w_hs) begin
        if (w_last_beat) begin
          r_rd  <= '0;
          r_cnt <= '0;
        end else begin
          r_rd <= r_rd + CW'(1);
        end
      end
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + 8'd1;
        2'b01:   r_outstanding <= r_outstanding - 8'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_b_hs && (m_axi_bresp != 2'b00)) r_bresp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data_buf[r_cnt[IW-1:0]] <= s_axis_tdata;
      r_strb_buf[r_cnt[IW-1:0]] <= w_strb_in;
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_base + r_wr_ptr;
  assign m_axi_awlen   = 8'(r_cnt - CW'(1));
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = w_awvalid;
  assign m_axi_wdata   = r_data_buf[r_rd[IW-1:0]];
  assign m_axi_wstrb   = r_strb_buf[r_rd[IW-1:0]];
  assign m_axi_wlast   = w_wvalid && w_last_beat;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_bready  = 1'b1;
  assign wr_ptr        = r_wr_ptr;
  assign pkt_count     = r_pkt_count;
  assign outstanding   = r_outstanding;
  assign bresp_err     = r_bresp_err;
endmodule

// File: tb/tb_axis_pkt_ring_axi4_writer.sv
module tb_axis_pkt_ring_axi4_writer;
  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int IDW = 4;
  localparam int BB  = DW / 8;
  localparam int MB  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]  s_axis_tdata;
  logic           s_axis_tvalid, s_axis_tready, s_axis_tlast;
`ifdef AXIS_RING_WRITER_TKEEP_EN
  logic [BB-1:0]  s_axis_tkeep = '1;
`endif
  logic [IDW-1:0] m_axi_awid;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]  m_axi_wdata;
  logic [BB-1:0]  m_axi_wstrb;
  logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [IDW-1:0] m_axi_bid;
  logic [1:0]     m_axi_bresp;
  logic           m_axi_bvalid, m_axi_bready;
  logic           enable;
  logic [AW-1:0]  ring_base, ring_size, wr_ptr;
  logic [31:0]    pkt_count;
  logic [7:0]     outstanding;
  logic           bresp_err;

  axis_pkt_ring_axi4_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .AXI_ID(0),
    .MAX_BURST(MB), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
`ifdef AXIS_RING_WRITER_TKEEP_EN
    .s_axis_tkeep(s_axis_tkeep),
`endif
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .enable(enable), .ring_base(ring_base), .ring_size(ring_size),
    .wr_ptr(wr_ptr), .pkt_count(pkt_count), .outstanding(outstanding),
    .bresp_err(bresp_err)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_t;
  aw_t exp_aw[$];
  w_t  exp_w[$];

  int n_checks = 0;
  int n_errors = 0;
  int aw_seen = 0, w_seen = 0, b_sent = 0;
  int b_mode = 1;      // 0: no responses, 1: random OKAY, 2: one SLVERR then hold
  bit rdy_rand = 0;
  logic [AW-1:0] last_awaddr = '0;

  // reference model state
  logic [AW-1:0] m_ptr, m_base, m_size;
  int m_pkts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic prev_stall;
    logic [AW-1:0] prev_addr;
    logic [7:0] prev_len;
    aw_t ea;
    w_t ew;
    prev_stall = 1'b0;
    prev_addr = '0;
    prev_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_aw.delete();
        exp_w.delete();
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("aw_hold_valid", 64'(m_axi_awvalid), 64'(1));
        chk("aw_hold_addr", 64'(m_axi_awaddr), 64'(prev_addr));
        chk("aw_hold_len", 64'(m_axi_awlen), 64'(prev_len));
      end
      prev_stall = m_axi_awvalid && !m_axi_awready;
      prev_addr = m_axi_awaddr;
      prev_len = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_seen++;
        last_awaddr = m_axi_awaddr;
        if (exp_aw.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL aw_unexpected: got addr 0x%0h, none expected", m_axi_awaddr);
        end else begin
          ea = exp_aw.pop_front();
          chk("awaddr", 64'(m_axi_awaddr), 64'(ea.addr));
          chk("awlen", 64'(m_axi_awlen), 64'(ea.len));
          chk("awsize", 64'(m_axi_awsize), 64'(6));
          chk("awburst", 64'(m_axi_awburst), 64'(1));
          chk("awid", 64'(m_axi_awid), 64'(0));
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_seen++;
        if (exp_w.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL w_unexpected: got W beat, none expected");
        end else begin
          ew = exp_w.pop_front();
          n_checks++;
          if (m_axi_wdata !== ew.data) begin
            n_errors++;
            $display("FAIL wdata: got %h expected %h", m_axi_wdata, ew.data);
          end
          chk("wlast", 64'(m_axi_wlast), 64'(ew.last));
          n_checks++;
          if (m_axi_wstrb !== {BB{1'b1}}) begin
            n_errors++;
            $display("FAIL wstrb: got %h expected all ones", m_axi_wstrb);
          end
        end
      end
    end
  end

  // AW/W ready generator
  initial begin
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_axi_awready = rdy_rand ? ($urandom % 4 != 0) : 1'b1;
      m_axi_wready  = rdy_rand ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  // B responder: one response per observed AW
  initial begin
    bit done2;
    done2 = 1'b0;
    m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00;
    m_axi_bid = '0;
    forever begin
      @(posedge clk); #3;
      m_axi_bvalid = 1'b0;
      if (rst) begin
        b_sent = aw_seen;
        done2 = 1'b0;
        continue;
      end
      if (b_mode != 2) done2 = 1'b0;
      if (aw_seen != b_sent) begin
        if (b_mode == 1 && ($urandom % 3 == 0)) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; b_sent++;
        end else if (b_mode == 2 && !done2) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; b_sent++; done2 = 1'b1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Split a packet into page/ring-bounded bursts and queue expectations,
  // then drive it into the stream port.
  task automatic send_pkt(input int nb, input bit drop_en);
    logic [DW-1:0] beats[$];
    aw_t a;
    w_t w;
    int rem, idx, room, b, t;
    bit acc;
    for (int i = 0; i < nb; i++) beats.push_back(rand_word());
    rem = nb;
    idx = 0;
    while (rem > 0) begin
      room = (4096 - int'(m_ptr % 4096)) / BB;
      b = rem;
      if (b > MB) b = MB;
      if (b > room) b = room;
      a.addr = m_base + m_ptr;
      a.len = 8'(b - 1);
      exp_aw.push_back(a);
      for (int j = 0; j < b; j++) begin
        w.data = beats[idx];
        w.last = (j == b - 1);
        exp_w.push_back(w);
        idx++;
      end
      m_ptr = m_ptr + AW'(b * BB);
      if (m_ptr == m_size) m_ptr = '0;
      rem -= b;
    end
    m_pkts++;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      if ($urandom % 4 == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = beats[i];
      s_axis_tlast = (i == nb - 1);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 2000) begin
        @(negedge clk);
        if (s_axis_tready) acc = 1'b1;
        t++;
      end
      if (!acc) begin
        n_checks++; n_errors++;
        $display("FAIL tready_timeout: beat %0d of %0d never accepted", i, nb);
        break;
      end
      @(posedge clk); #1;
      if (drop_en && i == 0) enable = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    enable = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (t < 5000) begin
      @(negedge clk);
      if (exp_aw.size() == 0 && exp_w.size() == 0 && !m_axi_awvalid && !m_axi_wvalid &&
          (b_mode != 1 || outstanding == 8'd0)) break;
      t++;
    end
    n_checks++;
    if (t >= 5000) begin
      n_errors++;
      $display("FAIL %s_drain_timeout: aw left %0d w left %0d", name, exp_aw.size(), exp_w.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tready_in_reset", 64'(s_axis_tready), 64'(0));
    chk("awvalid_in_reset", 64'(m_axi_awvalid), 64'(0));
    chk("wvalid_in_reset", 64'(m_axi_wvalid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = '0;
    m_pkts = 0;
  endtask

  initial begin
    int w0, t;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    enable = 1'b1;
    ring_base = 32'h1000_0000;
    ring_size = 32'h0001_0000;
    m_base = ring_base;
    m_size = ring_size;
    m_ptr = '0;
    m_pkts = 0;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_bresp_err", 64'(bresp_err), 64'(0));
    chk("rst_wlast", 64'(m_axi_wlast), 64'(0));
    chk("idle_tready", 64'(s_axis_tready), 64'(1));

    // 400 B packet -> single 7-beat burst
    send_pkt(7, 0);
    wait_idle("p7");
    chk("p7_wr_ptr", 64'(wr_ptr), 64'(32'h1C0));
    chk("p7_pkt_count", 64'(pkt_count), 64'(1));

    // 2048 B packet -> two 16-beat bursts
    do_reset();
    send_pkt(32, 0);
    wait_idle("p32");
    chk("p32_wr_ptr", 64'(wr_ptr), 64'(32'h800));
    chk("p32_last_awaddr", 64'(last_awaddr), 64'(32'h1000_0400));

    // 4 KiB split from offset 0xE00
    do_reset();
    send_pkt(56, 0);
    wait_idle("pre_e00");
    chk("e00_wr_ptr", 64'(wr_ptr), 64'(32'hE00));
    send_pkt(16, 0);
    wait_idle("p4k");
    chk("p4k_last_awaddr", 64'(last_awaddr), 64'(32'h1000_1000));
    chk("p4k_wr_ptr", 64'(wr_ptr), 64'(32'h1200));
    chk("p4k_pkt_count", 64'(pkt_count), 64'(2));

    // ring wrap with a 4 KiB ring
    ring_size = 32'h1000;
    m_size = ring_size;
    do_reset();
    send_pkt(62, 0);
    wait_idle("pre_f80");
    chk("f80_wr_ptr", 64'(wr_ptr), 64'(32'hF80));
    send_pkt(4, 0);
    wait_idle("wrap");
    chk("wrap_last_awaddr", 64'(last_awaddr), 64'(32'h1000_0000));
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'(32'h080));
    ring_size = 32'h0001_0000;
    m_size = ring_size;

    // outstanding limit and error response
    do_reset();
    b_mode = 0;
    for (int i = 0; i < 5; i++) send_pkt(1, 0);
    repeat (10) @(negedge clk);
    chk("lim_outstanding", 64'(outstanding), 64'(4));
    chk("lim_awvalid_low", 64'(m_axi_awvalid), 64'(0));
    chk("lim_aw_pending", 64'(exp_aw.size()), 64'(1));
    b_mode = 2;
    t = 0;
    while (exp_aw.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("lim_fifth_issued", 64'(exp_aw.size()), 64'(0));
    repeat (3) @(negedge clk);
    chk("lim_bresp_err", 64'(bresp_err), 64'(1));
    chk("lim_outstanding_after", 64'(outstanding), 64'(4));
    b_mode = 1;
    wait_idle("lim");
    chk("lim_drained", 64'(outstanding), 64'(0));
    chk("lim_err_sticky", 64'(bresp_err), 64'(1));
    chk("lim_pkt_count", 64'(pkt_count), 64'(5));

    // enable gating at packet start, ignored mid-packet
    do_reset();
    chk("en_err_cleared", 64'(bresp_err), 64'(0));
    @(posedge clk); #1;
    enable = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = rand_word();
    repeat (4) begin
      @(negedge clk);
      chk("en_off_tready", 64'(s_axis_tready), 64'(0));
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    enable = 1'b1;
    send_pkt(20, 1);
    wait_idle("en");
    chk("en_wr_ptr", 64'(wr_ptr), 64'(32'h500));
    chk("en_pkt_count", 64'(pkt_count), 64'(1));

    // reset during the third W beat of an 8-beat burst
    do_reset();
    rdy_rand = 0;
    w0 = w_seen;
    send_pkt(8, 0);
    t = 0;
    while (w_seen != w0 + 2 && t < 500) begin @(posedge clk); #2; t++; end
    chk("mid_rst_reached_beat3", 64'(w_seen - w0), 64'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wvalid", 64'(m_axi_wvalid), 64'(0));
    chk("mid_rst_wr_ptr", 64'(wr_ptr), 64'(0));
    chk("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("mid_rst_outstanding", 64'(outstanding), 64'(0));
    m_ptr = '0;
    m_pkts = 0;
    send_pkt(1, 0);
    wait_idle("after_rst");
    chk("after_rst_awaddr", 64'(last_awaddr), 64'(32'h1000_0000));
    chk("after_rst_wr_ptr", 64'(wr_ptr), 64'(32'h40));

    // randomized traffic with backpressure, two ring configurations
    rdy_rand = 1;
    for (int phase = 0; phase < 2; phase++) begin
      ring_base = (phase == 0) ? 32'h1000_0000 : 32'h2000_3000;
      ring_size = (phase == 0) ? 32'h0001_0000 : 32'h0000_2000;
      m_base = ring_base;
      m_size = ring_size;
      do_reset();
      for (int p = 0; p < 8; p++) send_pkt(int'($urandom_range(1, 40)), ($urandom % 3 == 0));
      wait_idle("rand");
      chk("rand_wr_ptr", 64'(wr_ptr), 64'(m_ptr));
      chk("rand_pkt_count", 64'(pkt_count), 64'(m_pkts));
      chk("rand_outstanding", 64'(outstanding), 64'(0));
      chk("rand_bresp_err", 64'(bresp_err), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
